// File: rtl/sent_pkg.sv
// Shared constants and encodings for the SENT CRC engine.
package sent_pkg;

   localparam logic [3:0] CRC4_POLY = 4'hD;   // x^4+x^3+x^2+1, implicit x^4
   localparam logic [3:0] CRC4_SEED = 4'h5;
   localparam logic [5:0] CRC6_POLY = 6'h19;  // x^6+x^4+x^3+1, implicit x^6
   localparam logic [5:0] CRC6_SEED = 6'h15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      AUG  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic {
      MODE_LEGACY      = 1'b0,
      MODE_RECOMMENDED = 1'b1
   } mode_e;

   typedef enum logic {
      TYPE_CRC4 = 1'b0,
      TYPE_CRC6 = 1'b1
   } type_e;

endpackage

// File: rtl/sent_crc_step.sv
// One combinational CRC update: folds UNIT_W data bits, MSB first, into the CRC.
module sent_crc_step #(
   parameter int unsigned       CRC_W  = 4,
   parameter int unsigned       UNIT_W = 4,
   parameter logic [CRC_W-1:0]  POLY   = '0
) (
   input  logic [CRC_W-1:0]  crc_i,
   input  logic [UNIT_W-1:0] unit_i,
   output logic [CRC_W-1:0]  crc_o
);

   logic [UNIT_W-1:0] unit_sh;

   always_comb begin
      crc_o   = crc_i;
      unit_sh = unit_i;
      for (int unsigned i = 0; i < UNIT_W; i++) begin
         if (crc_o[CRC_W-1] ^ unit_sh[UNIT_W-1]) begin
            crc_o = {crc_o[CRC_W-2:0], 1'b0} ^ POLY;
         end else begin
            crc_o = {crc_o[CRC_W-2:0], 1'b0};
         end
         unit_sh = unit_sh << 1;
      end
   end

endmodule

// File: rtl/sent_crc_engine.sv
// SENT CRC4/CRC6 engine with request/response handshakes.
// CRC6 support is compiled in only when SENT_CRC6_EN is defined.
module sent_crc_engine
   import sent_pkg::*;
#(
   parameter int unsigned MAX_NIBBLES = 8,
   parameter int unsigned LEN_W       = $clog2(MAX_NIBBLES + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_mode,
   input  logic                     req_type,
   input  logic [LEN_W-1:0]         req_len,
   input  logic [4*MAX_NIBBLES-1:0] req_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [5:0]               rsp_crc,
   output logic                     busy
);

   localparam int unsigned         DW   = 4 * MAX_NIBBLES;
   localparam int unsigned         SW   = DW + 2;  // two pad bits keep a 6-bit top slice legal
   localparam logic [DW-1:0]       ONES = '1;

   state_e            state_q;
   mode_e             mode_q;
   type_e             type_q;
   logic [LEN_W-1:0]  units_q;
   logic [SW-1:0]     data_q;
   logic [5:0]        crc_q;
   logic              req_ready_q, rsp_valid_q, busy_q;
   logic [5:0]        rsp_crc_q;

   mode_e             mode_in;
   type_e             type_in;
   logic [LEN_W-1:0]  len_c, units_in;
   logic [DW-1:0]     data_in;
   logic [5:0]        seed_in;
   logic [3:0]        unit4, crc4_nxt;
   logic [5:0]        crc_nxt;
   logic [SW-1:0]     data_sh;

   always_comb begin
      mode_in = mode_e'(req_mode);
`ifdef SENT_CRC6_EN
      type_in = type_e'(req_type);
`else
      type_in = TYPE_CRC4;
`endif
      len_c    = (req_len > LEN_W'(MAX_NIBBLES)) ? LEN_W'(MAX_NIBBLES) : req_len;
      units_in = len_c;
      if (type_in == TYPE_CRC6) begin
         units_in = LEN_W'((32'(len_c) * 32'd4 + 32'd5) / 32'd6);
      end
      // Nibbles past the length are zeroed so a partial CRC6 unit is zero-padded.
      data_in = req_data & ~(ONES >> (32'(len_c) * 32'd4));
      seed_in = (type_in == TYPE_CRC6) ? CRC6_SEED : {2'b00, CRC4_SEED};
      data_sh = (type_q == TYPE_CRC6) ? (data_q << 6) : (data_q << 4);
      unit4   = (state_q == AUG) ? 4'h0 : data_q[SW-1 -: 4];
   end

   sent_crc_step #(.CRC_W(4), .UNIT_W(4), .POLY(CRC4_POLY)) u_step4 (
      .crc_i  (crc_q[3:0]),
      .unit_i (unit4),
      .crc_o  (crc4_nxt)
   );

`ifdef SENT_CRC6_EN
   logic [5:0] unit6, crc6_nxt;

   always_comb unit6 = (state_q == AUG) ? 6'h00 : data_q[SW-1 -: 6];

   sent_crc_step #(.CRC_W(6), .UNIT_W(6), .POLY(CRC6_POLY)) u_step6 (
      .crc_i  (crc_q),
      .unit_i (unit6),
      .crc_o  (crc6_nxt)
   );

   always_comb crc_nxt = (type_q == TYPE_CRC6) ? crc6_nxt : {2'b00, crc4_nxt};
`else
   logic unused_crc6;

   always_comb crc_nxt = {2'b00, crc4_nxt};
   always_comb unused_crc6 = ^{req_type, crc_q[5:4]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= MODE_LEGACY;
         type_q      <= TYPE_CRC4;
         units_q     <= '0;
         data_q      <= '0;
         crc_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_crc_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  mode_q      <= mode_in;
                  type_q      <= type_in;
                  units_q     <= units_in;
                  data_q      <= {data_in, 2'b00};
                  crc_q       <= seed_in;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (units_in != '0) begin
                     state_q <= CALC;
                  end else if (mode_in == MODE_RECOMMENDED) begin
                     state_q <= AUG;
                  end else begin
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_crc_q   <= seed_in;
                  end
               end
            end
            CALC: begin
               crc_q   <= crc_nxt;
               data_q  <= data_sh;
               units_q <= units_q - LEN_W'(1);
               if (units_q == LEN_W'(1)) begin
                  if (mode_q == MODE_RECOMMENDED) begin
                     state_q <= AUG;
                  end else begin
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_crc_q   <= crc_nxt;
                  end
               end
            end
            AUG: begin
               crc_q       <= crc_nxt;
               state_q     <= DONE;
               rsp_valid_q <= 1'b1;
               rsp_crc_q   <= crc_nxt;
            end
            DONE: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_crc   = rsp_crc_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sent_crc_engine.sv
// Directed bench for sent_crc_engine; CRC6 expectations follow SENT_CRC6_EN.
module tb_sent_crc_engine;

   localparam int unsigned MAXN = 8;
   localparam int unsigned LW   = $clog2(MAXN + 1);

   logic            clk = 1'b0;
   logic            rst, req_valid, req_ready, req_mode, req_type;
   logic            rsp_valid, rsp_ready, busy;
   logic [LW-1:0]   req_len;
   logic [4*MAXN-1:0] req_data;
   logic [5:0]      rsp_crc;

   int n_checks = 0;
   int n_fail   = 0;
   logic [5:0] sb_crc[$];
   int         sb_lat[$];

   always #5 clk = ~clk;

   sent_crc_engine #(.MAX_NIBBLES(MAXN), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_mode  (req_mode),
      .req_type  (req_type),
      .req_len   (req_len),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_crc   (rsp_crc),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference: whole message as one MSB-first bit stream.
   function automatic logic [5:0] model(input bit mode, input bit typ, input int len,
                                        input logic [31:0] data);
      int         l;
      int         nbits;
      logic [31:0] d;
      logic [5:0] c;
      bit         fb;
      l = (len > MAXN) ? MAXN : len;
`ifndef SENT_CRC6_EN
      typ = 1'b0;
`endif
      d     = data & ~(32'hFFFF_FFFF >> (4 * l));
      c     = typ ? 6'h15 : 6'h05;
      nbits = typ ? ((4 * l + 5) / 6) * 6 : 4 * l;
      if (mode) nbits += typ ? 6 : 4;
      for (int i = 0; i < nbits; i++) begin
         fb = (typ ? c[5] : c[3]) ^ d[31];
         d  = d << 1;
         c  = typ ? {c[4:0], 1'b0} : {2'b00, c[2:0], 1'b0};
         if (fb) c = c ^ (typ ? 6'h19 : 6'h0D);
      end
      return c;
   endfunction

   function automatic int lat_of(input bit mode, input bit typ, input int len);
      int l;
      l = (len > MAXN) ? MAXN : len;
`ifndef SENT_CRC6_EN
      typ = 1'b0;
`endif
      return (typ ? (4 * l + 5) / 6 : l) + int'(mode) + 1;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 1);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_crc"},   rsp_crc,   0);
      check({tag, "_busy"},      busy,      0);
   endtask

   task automatic start(input bit mode, input bit typ, input int len,
                        input logic [31:0] data, input logic [5:0] exp);
      sb_crc.push_back(exp);
      sb_lat.push_back(lat_of(mode, typ, len));
      check("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_mode  = mode;
      req_type  = typ;
      req_len   = LW'(len);
      req_data  = data;
      @(posedge clk); #1;
      // Scramble inputs after accept; result must not change.
      req_valid = 1'b0;
      req_mode  = ~mode;
      req_type  = ~typ;
      req_len   = LW'($urandom_range(0, 15));
      req_data  = $urandom;
   endtask

   task automatic finish(input int hold);
      int         lat;
      int         el;
      logic [5:0] e;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      e  = sb_crc.pop_front();
      el = sb_lat.pop_front();
      check("rsp_valid", rsp_valid, 1);
      check("latency",   lat,       el);
      check("rsp_crc",   rsp_crc,   e);
      for (int i = 0; i < hold; i++) begin
         if (i == 2) begin
            req_valid = 1'b1;
            req_len   = LW'(3);
            req_data  = $urandom;
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         check("hold_valid", rsp_valid, 1);
         check("hold_crc",   rsp_crc,   e);
         check("hold_ready", req_ready, 0);
         check("hold_busy",  busy,      1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("post_valid", rsp_valid, 0);
      check("post_ready", req_ready, 1);
      check("post_busy",  busy,      0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      bit          m;
      int          l;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_mode  = 1'b0;
      req_type  = 1'b0;
      req_len   = '0;
      req_data  = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      start(1'b0, 1'b0, 1, 32'h5ABC_DEF1, 6'h00); finish(0);
      start(1'b0, 1'b0, 1, 32'h4000_0000, 6'h0D); finish(0);
      start(1'b1, 1'b0, 1, 32'h4123_4567, 6'h02); finish(0);
      start(1'b0, 1'b0, 0, 32'hDEAD_BEEF, 6'h05); finish(0);
      start(1'b1, 1'b0, 0, 32'h0000_0000, 6'h03); finish(0);
      d = 32'h9E37_79B9;
      start(1'b0, 1'b0, MAXN + 3, d, model(1'b0, 1'b0, MAXN, d)); finish(0);
      start(1'b0, 1'b0, MAXN,     d, model(1'b0, 1'b0, MAXN, d)); finish(5);

      for (int k = 0; k < 6; k++) begin
         d = $urandom;
         m = 1'($urandom_range(0, 1));
         l = $urandom_range(0, MAXN);
         start(m, 1'b0, l, d, model(m, 1'b0, l, d)); finish(k % 2);
      end

      for (int k = 0; k < 8; k++) begin
         d = $urandom;
         m = 1'(k % 2);
         start(m, 1'b1, 6, d, model(m, 1'b1, 6, d)); finish(0);
      end

      for (int k = 0; k < 4; k++) begin
         d = $urandom;
         m = 1'($urandom_range(0, 1));
         l = (k == 0) ? 1 : (k == 1) ? 5 : (k == 2) ? 7 : MAXN;
         start(m, 1'b1, l, d, model(m, 1'b1, l, d)); finish(0);
      end

      start(1'b0, 1'b0, 8, 32'h1234_5678, 6'h00);
      repeat (3) @(posedge clk);
      #1;
      check("midcalc_busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("midcalc_rst");
      rst = 1'b0;
      sb_crc.delete();
      sb_lat.delete();
      d = 32'hCAFE_F00D;
      start(1'b1, 1'b0, 8, d, model(1'b1, 1'b0, 8, d)); finish(0);
      d = $urandom;
      start(1'b1, 1'b1, 6, d, model(1'b1, 1'b1, 6, d)); finish(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
